// File: rtl/gray_ptr_rx_pkg.sv
// Shared constants, types and Gray/binary converters for the Gray-pointer receive side.
// Imported by the interface, the sync chain and the top level.
package gray_ptr_rx_pkg;

  localparam int N_DEFAULT           = 4;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Widest pointer the converters handle; callers zero-extend into this width.
  localparam int MAX_W = 32;

  // Buffer depth for an N-bit pointer whose MSB is the wrap bit.
  function automatic int depth_of(input int n);
    return 1 << (n - 1);
  endfunction

  typedef struct packed {
    logic ovf;
    logic udf;
  } err_flags_t;

  // Leading zeros from zero-extension do not disturb the prefix XOR.
  function automatic logic [MAX_W-1:0] gray_to_binary(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] binary_to_gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage : gray_ptr_rx_pkg

// File: rtl/gray_ptr_rx_if.sv
// Pointer/flag bundle between the remote-pointer source and the receive side.
// The master drives the remote pointer and the pop/clear requests; the slave is gray_ptr_rx.
interface gray_ptr_rx_if #(
  parameter int N = gray_ptr_rx_pkg::N_DEFAULT
);

  logic [N-1:0] i_gray_ptr;
  logic         i_pop;
  logic         i_err_clr;

  logic [N-1:0] o_rd_ptr;
  logic [N-1:0] o_rd_ptr_gray;
  logic [N-1:0] o_wr_ptr_bin;
  logic [N-1:0] o_level;
  logic         o_empty;
  logic         o_ovf_err;
  logic         o_udf_err;

  modport master (
    output i_gray_ptr,
    output i_pop,
    output i_err_clr,
    input  o_rd_ptr,
    input  o_rd_ptr_gray,
    input  o_wr_ptr_bin,
    input  o_level,
    input  o_empty,
    input  o_ovf_err,
    input  o_udf_err
  );

  modport slave (
    input  i_gray_ptr,
    input  i_pop,
    input  i_err_clr,
    output o_rd_ptr,
    output o_rd_ptr_gray,
    output o_wr_ptr_bin,
    output o_level,
    output o_empty,
    output o_ovf_err,
    output o_udf_err
  );

endinterface : gray_ptr_rx_if

// File: rtl/gray_ptr_rx_sync_vec.sv
// W-bit, STAGES-deep synchronizer chain; only Gray-coded (single-bit-change) vectors may pass.
// Shared with the write-side pointer crossing.
module sync_vec #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] stage_q;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every synchronizer flop is reset so a stale remote value never survives reset.
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
    end
  end

  assign q = stage_q[STAGES-1];

endmodule : sync_vec

// File: rtl/gray_ptr_rx.sv
// Read side of a dual-clock FIFO pointer pair: synchronizes the remote Gray write pointer,
// tracks the local read pointer and derives level, empty and sticky error flags.
module gray_ptr_rx
  import gray_ptr_rx_pkg::*;
#(
  parameter int N           = N_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input logic         clk,
  input logic         rst_n,
  gray_ptr_rx_if.slave bus
);

  localparam logic [N-1:0] DEPTH_N = N'(depth_of(N));
  localparam logic [N-1:0] ONE_N   = N'(1);

  logic [N-1:0] gray_sync;
  logic [N-1:0] wr_bin_d;
  logic [N-1:0] wr_bin_q;
  logic [N-1:0] rd_q;
  logic [N-1:0] rd_gray_q;
  logic [N-1:0] rd_next;
  logic [N-1:0] level;
  logic         empty;
  logic         pop_ok;
  err_flags_t   err_q;
  err_flags_t   err_set;

  sync_vec #(
    .W      (N),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.i_gray_ptr),
    .q     (gray_sync)
  );

  always_comb begin
    // NOTE: every signal here is assigned on every path, so no latch can be inferred.
    wr_bin_d    = N'(gray_to_binary(MAX_W'(gray_sync)));
    level       = wr_bin_q - rd_q;
    empty       = (level == '0);
    pop_ok      = bus.i_pop && !empty;
    rd_next     = rd_q + ONE_N;
    err_set.ovf = (level > DEPTH_N);
    err_set.udf = bus.i_pop && empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_bin_q  <= '0;
      rd_q      <= '0;
      rd_gray_q <= '0;
      err_q     <= '0;
    end else begin
      wr_bin_q <= wr_bin_d;
      if (pop_ok) begin
        rd_q      <= rd_next;
        // Gray copy comes from the next binary value so it never lags rd_q.
        rd_gray_q <= N'(binary_to_gray(MAX_W'(rd_next)));
      end
      // A new set condition beats a clear in the same cycle.
      err_q.ovf <= err_set.ovf || (err_q.ovf && !bus.i_err_clr);
      err_q.udf <= err_set.udf || (err_q.udf && !bus.i_err_clr);
    end
  end

  assign bus.o_rd_ptr      = rd_q;
  assign bus.o_rd_ptr_gray = rd_gray_q;
  assign bus.o_wr_ptr_bin  = wr_bin_q;
  assign bus.o_level       = level;
  assign bus.o_empty       = empty;
  assign bus.o_ovf_err     = err_q.ovf;
  assign bus.o_udf_err     = err_q.udf;

endmodule : gray_ptr_rx

// File: tb/tb_gray_ptr_rx.sv
// Self-checking bench for gray_ptr_rx (N=4, SYNC_STAGES=2): a scoreboard queue carries each
// driven remote pointer to the edge where it must appear on o_wr_ptr_bin.
module tb_gray_ptr_rx;

  localparam int N = 4;

  typedef struct {
    int         due;
    logic [3:0] val;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  gray_ptr_rx_if #(.N(N)) bus ();

  gray_ptr_rx #(
    .N           (N),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reflected binary Gray code for 0..15, written out independently of the RTL converter.
  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  sb_t        sb_q [$];
  logic [3:0] m_wr;
  logic [3:0] m_rd;
  logic       m_ovf;
  logic       m_udf;
  int         cyc;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  function automatic logic [3:0] m_level();
    return m_wr - m_rd;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".rd_ptr"},   bus.o_rd_ptr,      m_rd);
    check({tag, ".rd_gray"},  bus.o_rd_ptr_gray, gray_tab[m_rd]);
    check({tag, ".wr_bin"},   bus.o_wr_ptr_bin,  m_wr);
    check({tag, ".level"},    bus.o_level,       m_level());
    check({tag, ".empty"},    bus.o_empty,       m_level() == 4'd0);
    check({tag, ".ovf"},      bus.o_ovf_err,     m_ovf);
    check({tag, ".udf"},      bus.o_udf_err,     m_udf);
  endtask

  // One clock of stimulus: drive, take the edge, advance the model, compare.
  task automatic step(input logic [3:0] bin, input logic pop, input logic clr);
    logic [3:0] lvl;
    sb_t        e;
    bus.i_gray_ptr = gray_tab[bin];
    bus.i_pop      = pop;
    bus.i_err_clr  = clr;
    lvl = m_level();
    sb_q.push_back('{due: cyc + 3, val: bin});
    @(posedge clk);
    #1;
    cyc++;
    m_udf = (pop && lvl == 4'd0) || (m_udf && !clr);
    m_ovf = (lvl > 4'd8) || (m_ovf && !clr);
    if (pop && lvl != 4'd0) m_rd = m_rd + 4'd1;
    while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      check("sb.wr_ptr_bin", bus.o_wr_ptr_bin, e.val);
      m_wr = e.val;
    end
    check_all("step");
  endtask

  task automatic apply_reset(input logic [3:0] bin);
    bus.i_gray_ptr = gray_tab[bin];
    bus.i_pop      = 1'b0;
    bus.i_err_clr  = 1'b0;
    rst_n          = 1'b0;
    #1;
    m_wr  = '0;
    m_rd  = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    cyc   = 0;
    sb_q.delete();
    check_all("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench did not finish in time");
  end

  initial begin
    // Reset with a non-zero remote pointer held; it must appear three edges after release.
    apply_reset(4'd4);
    repeat (3) step(4'd4, 1'b0, 1'b0);
    check("t1.wr_bin_4", bus.o_wr_ptr_bin, 4);

    // Remote pointer counts 0..3, one step per two cycles, no pops.
    apply_reset(4'd0);
    for (int b = 0; b < 4; b++) begin
      repeat (2) step(4'(b), 1'b0, 1'b0);
    end
    repeat (3) step(4'd3, 1'b0, 1'b0);
    check("t2.level_3", bus.o_level, 3);
    check("t2.not_empty", bus.o_empty, 0);

    // Four pops against three entries: last one underflows.
    repeat (4) step(4'd3, 1'b1, 1'b0);
    check("t3.rd_3", bus.o_rd_ptr, 3);
    check("t3.rd_gray_2", bus.o_rd_ptr_gray, 2);
    check("t3.udf", bus.o_udf_err, 1);
    check("t3.empty", bus.o_empty, 1);
    step(4'd3, 1'b0, 1'b1);
    check("t3.udf_clr", bus.o_udf_err, 0);

    // Walk both pointers up to 14 without errors, then cross the wrap.
    apply_reset(4'd0);
    for (int b = 1; b <= 14; b++) begin
      repeat (2) step(4'(b), m_level() != 4'd0, 1'b0);
    end
    repeat (6) step(4'd14, m_level() != 4'd0, 1'b0);
    check("t4.rd_14", bus.o_rd_ptr, 14);
    step(4'd15, 1'b0, 1'b0);
    step(4'd0,  1'b0, 1'b0);
    step(4'd1,  1'b0, 1'b0);
    repeat (4) step(4'd2, 1'b0, 1'b0);
    check("t4.level_4", bus.o_level, 4);
    repeat (4) step(4'd2, 1'b1, 1'b0);
    check("t4.rd_2", bus.o_rd_ptr, 2);
    check("t4.empty", bus.o_empty, 1);
    check("t4.no_ovf", bus.o_ovf_err, 0);
    check("t4.no_udf", bus.o_udf_err, 0);

    // Overflow: level 9 against depth 8; clear loses while the condition holds.
    apply_reset(4'd0);
    repeat (3) step(4'd9, 1'b0, 1'b0);
    check("t5.level_9", bus.o_level, 9);
    step(4'd9, 1'b0, 1'b0);
    check("t5.ovf_set", bus.o_ovf_err, 1);
    step(4'd9, 1'b0, 1'b1);
    check("t5.ovf_set_wins", bus.o_ovf_err, 1);
    step(4'd9, 1'b1, 1'b0);
    check("t5.level_8", bus.o_level, 8);
    step(4'd9, 1'b0, 1'b1);
    check("t5.ovf_clr", bus.o_ovf_err, 0);

    // Pop lands on the same edge as a remote advance: level holds at 2.
    apply_reset(4'd0);
    repeat (3) step(4'd2, 1'b0, 1'b0);
    check("t6.level_2", bus.o_level, 2);
    step(4'd3, 1'b0, 1'b0);
    step(4'd3, 1'b0, 1'b0);
    step(4'd3, 1'b1, 1'b0);
    check("t6.level_hold", bus.o_level, 2);
    check("t6.rd_1", bus.o_rd_ptr, 1);
    step(4'd4, 1'b1, 1'b0);

    // Asynchronous reset in the middle of activity, checked before any clock edge.
    apply_reset(4'd0);
    check("t7.rd_0", bus.o_rd_ptr, 0);
    check("t7.empty", bus.o_empty, 1);
    repeat (4) step(4'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gray_ptr_rx
